// File: rtl/ps2_command_controller.sv
// PS/2 host-to-device command sequencer: request-to-send, clocks the frame out on device
// edges, checks the line ACK, then waits for the device response with resend/timeout retries.
module ps2_command_controller #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_start,
    input  logic [7:0] cmd_data,
    input  logic       edge_found,
    input  logic       ps2_data_in,
    input  logic [7:0] rx_scancode,
    input  logic       scancode_ready_set,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] response
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RET_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_RTS  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_MAX  = RET_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_RESP,
        S_RETRY,
        S_FINISH
    } state_t;

    state_t           state;
    logic [7:0]       cmd_reg;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       edge_cnt;
    logic [RET_W-1:0] retry_cnt;

    // Data-line drive after device edge n (1..10): data bits LSB first, odd parity, released stop.
    function automatic logic frame_oe(input logic [7:0] cmd, input logic [3:0] n);
        if (n <= 4'd8)
            return ~cmd[n[2:0] - 3'd1];
        else if (n == 4'd9)
            return ^cmd;
        else
            return 1'b0;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            inh_cnt      <= '0;
            to_cnt       <= '0;
            edge_cnt     <= '0;
            retry_cnt    <= '0;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            rx_inhibit   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            response     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_FINISH: begin
                    retry_cnt <= '0;
                    state     <= S_IDLE;
                    if (cmd_start) begin
                        cmd_reg      <= cmd_data;
                        error        <= 1'b0;
                        busy         <= 1'b1;
                        ps2_clock_oe <= 1'b1;
                        rx_inhibit   <= 1'b1;
                        inh_cnt      <= '0;
                        state        <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    // Data goes low one cycle before the clock line is released (request-to-send).
                    if (inh_cnt == INH_RTS)
                        ps2_data_oe <= 1'b1;
                    if (inh_cnt == INH_LAST) begin
                        ps2_clock_oe <= 1'b0;
                        ps2_data_oe  <= 1'b1;
                        edge_cnt     <= '0;
                        to_cnt       <= '0;
                        state        <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (edge_found) begin
                        to_cnt   <= '0;
                        edge_cnt <= edge_cnt + 4'd1;
                        if (edge_cnt == 4'd10) begin
                            ps2_data_oe <= 1'b0;
                            if (ps2_data_in) begin
                                state <= S_RETRY;
                            end else begin
                                rx_inhibit <= 1'b0;
                                state      <= S_RESP;
                            end
                        end else begin
                            ps2_data_oe <= frame_oe(cmd_reg, edge_cnt + 4'd1);
                        end
                    end else if (to_cnt == TO_LAST) begin
                        ps2_clock_oe <= 1'b0;
                        ps2_data_oe  <= 1'b0;
                        state        <= S_RETRY;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (scancode_ready_set) begin
                        response <= rx_scancode;
                        if (rx_scancode == 8'hFE) begin
                            state <= S_RETRY;
                        end else begin
                            error <= (rx_scancode != 8'hFA);
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_FINISH;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state <= S_RETRY;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                S_RETRY: begin
                    if (retry_cnt < RET_MAX) begin
                        retry_cnt    <= retry_cnt + 1'b1;
                        ps2_clock_oe <= 1'b1;
                        rx_inhibit   <= 1'b1;
                        inh_cnt      <= '0;
                        state        <= S_INHIBIT;
                    end else begin
                        rx_inhibit <= 1'b0;
                        error      <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_FINISH;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_command_controller.sv
// Bench for ps2_command_controller: a PS/2 device model drives edges, ACK/NACK and replies;
// directed table rows, hand-written corner sequences and random transactions against a reference model.
module tb_ps2_command_controller;

    localparam int INH  = 10;
    localparam int TMO  = 100;
    localparam int MAXR = 3;

    localparam logic [1:0] M_ACK    = 2'd0;
    localparam logic [1:0] M_NACK   = 2'd1;
    localparam logic [1:0] M_STALL  = 2'd2;
    localparam logic [1:0] M_SILENT = 2'd3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_start = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       edge_found = 1'b0;
    logic       ps2_data_in = 1'b1;
    logic [7:0] rx_scancode = 8'h00;
    logic       scancode_ready_set = 1'b0;
    logic       ps2_clock_oe, ps2_data_oe, rx_inhibit, busy, done, error;
    logic [7:0] response;

    int   checks = 0;
    int   errors = 0;
    int   inh_seen = 0;
    int   done_seen = 0;
    int   busy_gap = 0;
    logic track = 1'b0;
    logic prev_coe = 1'b0;

    typedef struct {
        logic [7:0]      cmd;
        logic [3:0][1:0] mode;
        logic [3:0][7:0] reply;
        int              n;
        logic            err;
        logic [7:0]      resp;
        logic            par;
    } vec_t;

    vec_t tbl [9];

    ps2_command_controller #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES(MAXR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd_start(cmd_start),
        .cmd_data(cmd_data),
        .edge_found(edge_found),
        .ps2_data_in(ps2_data_in),
        .rx_scancode(rx_scancode),
        .scancode_ready_set(scancode_ready_set),
        .ps2_clock_oe(ps2_clock_oe),
        .ps2_data_oe(ps2_data_oe),
        .rx_inhibit(rx_inhibit),
        .busy(busy),
        .done(done),
        .error(error),
        .response(response)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
        if (ps2_clock_oe && !prev_coe) inh_seen++;
        prev_coe = ps2_clock_oe;
        if (done) done_seen++;
        if (track && !busy && !done) busy_gap++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clock_oe"}, ps2_clock_oe, 0);
        check({tag, "_data_oe"}, ps2_data_oe, 0);
        check({tag, "_rx_inhibit"}, rx_inhibit, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_response"}, response, 0);
    endtask

    function automatic vec_t mk(input logic [7:0] cmd, input logic [3:0][1:0] mode,
                                input logic [3:0][7:0] reply, input int n, input logic err,
                                input logic [7:0] resp, input logic par);
        vec_t v;
        v.cmd = cmd; v.mode = mode; v.reply = reply;
        v.n = n; v.err = err; v.resp = resp; v.par = par;
        return v;
    endfunction

    // Reference outcome: walk the attempts, stop on a final reply or when retries run out.
    function automatic void model(input logic [3:0][1:0] mode, input logic [3:0][7:0] reply,
                                  input logic [7:0] prev, output int n, output logic err,
                                  output logic [7:0] resp);
        logic stop;
        stop = 1'b0; resp = prev; err = 1'b1; n = 0;
        for (int i = 0; i <= MAXR; i++) begin
            if (!stop) begin
                n = i + 1;
                if (mode[i] == M_ACK) begin
                    resp = reply[i];
                    if (reply[i] == 8'hFA) begin
                        err = 1'b0; stop = 1'b1;
                    end else if (reply[i] != 8'hFE) begin
                        stop = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic wait_send(output int len, output logic rts);
        int n;
        n = 0;
        while (!ps2_clock_oe && n < 600) begin tick(); n++; end
        check("inhibit_begin", ps2_clock_oe, 1);
        len = 0; rts = 1'b0;
        while (ps2_clock_oe && len < 1000) begin
            rts = ps2_data_oe;
            len++;
            edge_found = ($urandom_range(0, 7) == 0);
            tick();
        end
        edge_found = 1'b0;
    endtask

    task automatic pulse_edge(input logic din, output logic level);
        repeat ($urandom_range(1, 3)) tick();
        edge_found = 1'b1; ps2_data_in = din;
        tick();
        edge_found = 1'b0; ps2_data_in = 1'b1;
        level = ~ps2_data_oe;
    endtask

    task automatic attempt(input logic [7:0] cmd, input logic [1:0] mode, input logic [7:0] reply,
                           input logic par);
        int         len, ne;
        logic       rts, lv;
        logic [9:0] obs;
        wait_send(len, rts);
        check("inhibit_len", len, INH);
        check("rts_data_low", rts, 1);
        check("start_bit_oe", ps2_data_oe, 1);
        check("rx_inhibit_send", rx_inhibit, 1);
        ne  = (mode == M_STALL) ? 5 : 11;
        obs = '0;
        for (int k = 1; k <= ne; k++) begin
            pulse_edge((k == 11) ? (mode == M_NACK) : 1'b1, lv);
            if (k <= 10) obs[k-1] = lv;
        end
        if (ne == 11) begin
            check("frame_data", obs[7:0], cmd);
            check("frame_parity", obs[8], par);
            check("frame_stop", obs[9], 1);
        end
        if (mode == M_ACK) begin
            repeat ($urandom_range(1, 4)) tick();
            check("rx_inhibit_resp", rx_inhibit, 0);
            scancode_ready_set = 1'b1; rx_scancode = reply;
            tick();
            scancode_ready_set = 1'b0; rx_scancode = 8'($urandom);
            check("done_after_reply", done, reply != 8'hFE);
            check("busy_after_reply", busy, reply == 8'hFE);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int n;
        inh_seen = 0; done_seen = 0; busy_gap = 0;
        tick();
        cmd_data = v.cmd; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0; cmd_data = 8'($urandom);
        check("busy_t1", busy, 1);
        check("clock_oe_t1", ps2_clock_oe, 1);
        check("error_cleared", error, 0);
        track = 1'b1;
        for (int i = 0; i < v.n; i++) attempt(v.cmd, v.mode[i], v.reply[i], v.par);
        n = 0;
        while (done_seen == 0 && n < 400) begin tick(); n++; end
        track = 1'b0;
        repeat (3) tick();
        check("done_pulses", done_seen, 1);
        check("error", error, v.err);
        check("response", response, v.resp);
        check("inhibit_periods", inh_seen, v.n);
        check("busy_gap", busy_gap, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        int         len, n;
        logic       rts, lv;
        logic [4:0] obs;
        logic [7:0] c, prev;
        vec_t       v;

        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;

        // Stray edges and scancodes while idle must not move anything.
        tick();
        edge_found = 1'b1; scancode_ready_set = 1'b1; rx_scancode = 8'h77;
        tick();
        edge_found = 1'b0; scancode_ready_set = 1'b0;
        repeat (2) tick();
        check_all_zero("idle_ignore");

        tbl[0] = mk(8'hF4, {M_ACK, M_ACK, M_ACK, M_ACK}, {8'h00, 8'h00, 8'h00, 8'hFA}, 1, 1'b0, 8'hFA, 1'b0);
        tbl[1] = mk(8'hED, {M_ACK, M_ACK, M_ACK, M_ACK}, {8'h00, 8'h00, 8'h00, 8'hFA}, 1, 1'b0, 8'hFA, 1'b1);
        tbl[2] = mk(8'h00, {M_ACK, M_ACK, M_ACK, M_ACK}, {8'h00, 8'h00, 8'h00, 8'hFA}, 1, 1'b0, 8'hFA, 1'b1);
        tbl[3] = mk(8'h01, {M_ACK, M_ACK, M_ACK, M_ACK}, {8'h00, 8'h00, 8'h00, 8'hFA}, 1, 1'b0, 8'hFA, 1'b0);
        tbl[4] = mk(8'hF3, {M_ACK, M_ACK, M_ACK, M_ACK}, {8'h00, 8'h00, 8'hFA, 8'hFE}, 2, 1'b0, 8'hFA, 1'b1);
        tbl[5] = mk(8'hED, {M_NACK, M_NACK, M_NACK, M_NACK}, 32'h0, 4, 1'b1, 8'hFA, 1'b1);
        tbl[6] = mk(8'h55, {M_ACK, M_ACK, M_ACK, M_ACK}, {8'h00, 8'h00, 8'h00, 8'hAA}, 1, 1'b1, 8'hAA, 1'b1);
        tbl[7] = mk(8'h20, {M_STALL, M_STALL, M_STALL, M_STALL}, 32'h0, 4, 1'b1, 8'hAA, 1'b0);
        tbl[8] = mk(8'h10, {M_ACK, M_ACK, M_ACK, M_SILENT}, {8'h00, 8'h00, 8'hFA, 8'h00}, 2, 1'b0, 8'hFA, 1'b0);
        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        // Device stops after 5 edges: lines release after the timeout and a retry begins.
        tick();
        cmd_data = 8'h00; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        wait_send(len, rts);
        for (int k = 1; k <= 5; k++) pulse_edge(1'b1, lv);
        n = 0;
        while (ps2_data_oe && n < 300) begin tick(); n++; end
        check_range("timeout_release", n, TMO - 1, TMO + 1);
        check("timeout_clock_oe", ps2_clock_oe, 0);
        n = 0;
        while (!ps2_clock_oe && n < 20) begin tick(); n++; end
        check("retry_after_timeout", ps2_clock_oe, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Second cmd_start mid-frame is ignored; reset at edge 6 aborts silently.
        done_seen = 0;
        c = 8'hA5;
        tick();
        cmd_data = c; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        wait_send(len, rts);
        for (int k = 1; k <= 5; k++) begin
            pulse_edge(1'b1, lv);
            obs[k-1] = lv;
            if (k == 3) begin
                cmd_data = 8'h3C; cmd_start = 1'b1;
                tick();
                cmd_start = 1'b0;
                check("busy_mid_frame", busy, 1);
            end
        end
        check("bits_unchanged", obs, c[4:0]);
        repeat (2) tick();
        edge_found = 1'b1; reset = 1'b1;
        tick();
        edge_found = 1'b0; reset = 1'b0;
        check_all_zero("reset_mid_frame");
        repeat (5) tick();
        check("no_done_after_reset", done_seen, 0);
        check("idle_after_reset", ps2_clock_oe | busy, 0);

        prev = 8'h00;
        for (int t = 0; t < 25; t++) begin
            v.cmd = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                n = $urandom_range(0, 9);
                v.mode[i]  = (n < 6) ? M_ACK : (n < 8) ? M_NACK : (n < 9) ? M_STALL : M_SILENT;
                n = $urandom_range(0, 9);
                v.reply[i] = (n < 5) ? 8'hFA : (n < 8) ? 8'hFE : 8'($urandom);
            end
            model(v.mode, v.reply, prev, v.n, v.err, v.resp);
            v.par = ($countones(v.cmd) % 2 == 0);
            run_txn(v);
            prev = v.resp;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
